// File: rtl/neander_pkg.sv
// Shared definitions for the Neander register-pair datapath.
// The slot codes double as the dual register's load-enable encoding.
package neander_pkg;

    localparam logic [1:0] SLOT_NONE = 2'b00;
    localparam logic [1:0] SLOT_1    = 2'b01;
    localparam logic [1:0] SLOT_2    = 2'b10;
    localparam logic [1:0] SLOT_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2
    } pair_state_t;

endpackage

// File: rtl/reg8b_pair_reader_if.sv
// Pair-in / word-out handshake bundle for reg8b_pair_reader.
// The master modport is the reader block, and the slave modport is its surroundings.
interface reg8b_pair_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mask;
    logic [DATA_WIDTH-1:0] data_in_1;
    logic [DATA_WIDTH-1:0] data_in_2;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_sel;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  in_valid, in_mask, data_in_1, data_in_2, out_ready,
        output in_ready, out_valid, out_sel, data_out
    );

    modport slave (
        output in_valid, in_mask, data_in_1, data_in_2, out_ready,
        input  in_ready, out_valid, out_sel, data_out
    );
endinterface

// File: rtl/reg8b_pair_reader.sv
// Serialises a buffered word pair onto a single slot-tagged output bus.
// FSM states:
//   state | meaning
//   IDLE  | no word pending, ready for a new pair
//   SEND1 | presenting buffered word 1 (out_sel = 01)
//   SEND2 | presenting buffered word 2 (out_sel = 10)
module reg8b_pair_reader
    import neander_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg8b_pair_reader_if.master  bus,
    output logic [CNT_WIDTH-1:0] words_sent
);

    pair_state_t           state;
    logic [DATA_WIDTH-1:0] buf_1;
    logic [DATA_WIDTH-1:0] buf_2;
    logic [1:0]            buf_mask;

    logic                  final_word;
    logic                  accept;
    logic                  xfer;
    pair_state_t           first_state;
    logic [1:0]            first_sel;
    logic [DATA_WIDTH-1:0] first_data;

    assign final_word   = (state == SEND2) || ((state == SEND1) && (buf_mask != SLOT_BOTH));
    assign bus.in_ready = (state == IDLE) || (final_word && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = bus.out_valid && bus.out_ready;

    // Where a freshly accepted pair starts, taken straight from the input pins.
    always_comb begin
        first_state = IDLE;
        first_sel   = SLOT_NONE;
        first_data  = '0;
        case (bus.in_mask)
            SLOT_1, SLOT_BOTH: begin
                first_state = SEND1;
                first_sel   = SLOT_1;
                first_data  = bus.data_in_1;
            end
            SLOT_2: begin
                first_state = SEND2;
                first_sel   = SLOT_2;
                first_data  = bus.data_in_2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            buf_1         <= '0;
            buf_2         <= '0;
            buf_mask      <= SLOT_NONE;
            bus.out_valid <= 1'b0;
            bus.out_sel   <= SLOT_NONE;
            bus.data_out  <= '0;
            words_sent    <= '0;
        end else begin
            if (xfer) begin
                words_sent <= words_sent + 1'b1;
            end
            if (accept) begin
                buf_1    <= bus.data_in_1;
                buf_2    <= bus.data_in_2;
                buf_mask <= bus.in_mask;
            end

            if ((state == SEND1) && xfer && (buf_mask == SLOT_BOTH)) begin
                state         <= SEND2;
                bus.out_valid <= 1'b1;
                bus.out_sel   <= SLOT_2;
                bus.data_out  <= buf_2;
            end else if (accept) begin
                // Covers both the idle accept and a pair chained onto the final word.
                state         <= first_state;
                bus.out_valid <= (first_state != IDLE);
                bus.out_sel   <= first_sel;
                bus.data_out  <= first_data;
            end else if (final_word && xfer) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_sel   <= SLOT_NONE;
                bus.data_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reg8b_pair_reader.sv
// Directed-vector bench for reg8b_pair_reader, including a 2-bit counter
// instance for the words_sent wrap.
module tb_reg8b_pair_reader;
    import neander_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] words_sent;
    logic [1:0] words_sent_w;
    int         n_checks = 0;
    int         n_errors = 0;

    reg8b_pair_reader_if #(.DATA_WIDTH(8)) bus ();
    reg8b_pair_reader_if #(.DATA_WIDTH(8)) bus_w ();

    reg8b_pair_reader #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .words_sent (words_sent)
    );

    reg8b_pair_reader #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_w.master),
        .words_sent (words_sent_w)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [1:0] sel,
                             input logic [7:0] data);
        check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
        check_eq({tag, ".out_sel"},   32'(bus.out_sel),   32'(sel));
        check_eq({tag, ".data_out"},  32'(bus.data_out),  32'(data));
    endtask

    task automatic drive_pair(input logic [1:0] mask, input logic [7:0] d1, input logic [7:0] d2);
        bus.in_valid  = 1'b1;
        bus.in_mask   = mask;
        bus.data_in_1 = d1;
        bus.data_in_2 = d2;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_mask     = SLOT_NONE;
        bus.data_in_1   = '0;
        bus.data_in_2   = '0;
        bus.out_ready   = 1'b0;
        bus_w.in_valid  = 1'b0;
        bus_w.in_mask   = SLOT_NONE;
        bus_w.data_in_1 = '0;
        bus_w.data_in_2 = '0;
        bus_w.out_ready = 1'b1;

        // Reset then idle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check_out("rst", 1'b0, 2'b00, 8'h00);
        check_eq("rst.words_sent", 32'(words_sent), 32'd0);

        // Both slots, no backpressure
        bus.out_ready = 1'b1;
        drive_pair(2'b11, 8'hA5, 8'h3C);
        tick();
        bus.in_valid = 1'b0;
        settle();
        check_out("both.w1", 1'b1, 2'b01, 8'hA5);
        check_eq("both.w1.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check_out("both.w2", 1'b1, 2'b10, 8'h3C);
        check_eq("both.w2.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("both.idle", 1'b0, 2'b00, 8'h00);
        check_eq("both.words_sent", 32'(words_sent), 32'd2);

        // Single slot 2
        drive_pair(2'b10, 8'h55, 8'h7E);
        tick();
        bus.in_valid = 1'b0;
        check_out("s2.w", 1'b1, 2'b10, 8'h7E);
        tick();
        check_out("s2.idle", 1'b0, 2'b00, 8'h00);
        check_eq("s2.words_sent", 32'(words_sent), 32'd3);

        // Empty mask: consumed, nothing emitted
        drive_pair(2'b00, 8'h99, 8'h66);
        tick();
        bus.in_valid = 1'b0;
        check_out("m0", 1'b0, 2'b00, 8'h00);
        check_eq("m0.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("m0.later", 1'b0, 2'b00, 8'h00);
        check_eq("m0.words_sent", 32'(words_sent), 32'd3);

        // Backpressure in SEND1; input changes must be ignored
        bus.out_ready = 1'b0;
        drive_pair(2'b11, 8'h11, 8'h22);
        tick();
        drive_pair(2'b10, 8'hEE, 8'hDD);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_out($sformatf("bp.stall%0d", i), 1'b1, 2'b01, 8'h11);
            check_eq($sformatf("bp.stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        settle();
        check_out("bp.release", 1'b1, 2'b01, 8'h11);
        tick();
        check_out("bp.w2", 1'b1, 2'b10, 8'h22);
        tick();
        check_out("bp.idle", 1'b0, 2'b00, 8'h00);
        check_eq("bp.words_sent", 32'(words_sent), 32'd5);

        // Back-to-back pairs with no bubble
        drive_pair(2'b11, 8'h01, 8'h02);
        tick();
        drive_pair(2'b01, 8'h03, 8'h04);
        settle();
        check_out("b2b.w1", 1'b1, 2'b01, 8'h01);
        tick();
        check_out("b2b.w2", 1'b1, 2'b10, 8'h02);
        check_eq("b2b.w2.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out("b2b.w3", 1'b1, 2'b01, 8'h03);
        tick();
        check_out("b2b.idle", 1'b0, 2'b00, 8'h00);
        check_eq("b2b.words_sent", 32'(words_sent), 32'd8);

        // Reset mid-transfer with a simultaneous handshake
        bus.out_ready = 1'b0;
        drive_pair(2'b11, 8'hAA, 8'hBB);
        tick();
        bus.in_valid = 1'b0;
        check_out("midrst.pre", 1'b1, 2'b01, 8'hAA);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        check_out("midrst.post", 1'b0, 2'b00, 8'h00);
        check_eq("midrst.words_sent", 32'(words_sent), 32'd0);
        check_eq("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_out("midrst.later", 1'b0, 2'b00, 8'h00);

        // 2-bit counter wraps after four transfers
        for (int i = 0; i < 5; i++) begin
            bus_w.in_valid  = 1'b1;
            bus_w.in_mask   = SLOT_1;
            bus_w.data_in_1 = 8'(i + 16);
            tick();
            bus_w.in_valid = 1'b0;
            check_eq($sformatf("wrap.data%0d", i), 32'(bus_w.data_out), 32'(i + 16));
            tick();
            if (i == 3) check_eq("wrap.words_sent4", 32'(words_sent_w), 32'd0);
        end
        check_eq("wrap.words_sent5", 32'(words_sent_w), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg8b_pair_reader.md
Name: reg8b_pair_reader

Overview:
- Read-side counterpart of the dual 8-bit register.
- Accepts a pair of DATA_WIDTH-bit words plus a 2-bit slot mask, and emits the selected words one at a time on a single output bus with a valid/ready handshake.
- Tags each output word with the slot code (01 = slot 1, 10 = slot 2), so a downstream dual register can load it directly.
- Sits between the Neander datapath register pair and the shared 8-bit bus/memory write path.

Parameters:
- DATA_WIDTH, 8, width of each data word and of data_out.
- CNT_WIDTH, 8, width of the words-sent counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream presents a pair.
- in_ready  output  1  block can accept a pair this cycle.
- in_mask  input  2  slot select: 01 = slot 1 only, 10 = slot 2 only, 11 = slot 1 then slot 2, 00 = no words.
- data_in_1  input  DATA_WIDTH  slot 1 word.
- data_in_2  input  DATA_WIDTH  slot 2 word.
- out_valid  output  1  data_out/out_sel are valid.
- out_ready  input  1  downstream accepts the current word.
- out_sel  output  2  slot code of the current word (01 or 10); 00 when idle.
- data_out  output  DATA_WIDTH  current word.
- words_sent  output  CNT_WIDTH  count of completed output transfers, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: one clock edge with rst_n = 0 forces:
  - state IDLE;
  - in_ready = 1, out_valid = 0, out_sel = 00;
  - data_out = 0, words_sent = 0, internal buffers = 0.
  - Reset mid-transfer discards any pending word with no output.
- Transfer rules:
  - An input transfer occurs on a rising edge where in_valid & in_ready.
  - An output transfer occurs on a rising edge where out_valid & out_ready.
- On input accept, capture data_in_1, data_in_2 and in_mask into internal registers.
- FSM states:
  - IDLE: out_valid = 0. On accept:
    - mask 01 or 11 → SEND1;
    - mask 10 → SEND2;
    - mask 00 → stay in IDLE (pair consumed, nothing emitted).
  - SEND1: out_valid = 1, out_sel = 01, data_out = buffered word 1. On output transfer:
    - buffered mask 11 → SEND2;
    - otherwise → LAST handling (below).
  - SEND2: out_valid = 1, out_sel = 10, data_out = buffered word 2. On output transfer → LAST handling.
- LAST handling (final word of a pair):
  - in_ready is asserted combinationally during the final word, equal to out_ready.
  - If a new pair is accepted on the same edge, go directly to its first state (SEND1/SEND2). A mask-00 pair goes to IDLE.
  - Otherwise go to IDLE.
- in_ready = (state == IDLE) | (final word & out_ready). It is never asserted while a non-final word is pending.
- Outputs out_valid, out_sel and data_out are registered (driven from state/buffers):
  - Latency: pair accepted at edge N → first word valid after edge N.
  - Throughput: one word per cycle, including back-to-back pairs.
- Stalls:
  - While out_valid & !out_ready, data_out and out_sel hold stable.
  - in_data changes are ignored while stalled.
- words_sent increments by 1 on every output transfer; 2^CNT_WIDTH − 1 wraps to 0.
- Simultaneous reset and handshake: reset wins, and no transfer is counted.

Decomposition:
- Shared package neander_pkg:
  - slot codes SLOT_NONE = 2'b00, SLOT_1 = 2'b01, SLOT_2 = 2'b10, SLOT_BOTH = 2'b11;
  - FSM state typedef {IDLE, SEND1, SEND2}.
- The slot codes are shared with the dual register's enable encoding.
- No sub-module is needed. The pair buffer is a plain registered capture in the top-level.

Test Plan:
1. Reset then idle:
   - Stimulus: hold rst_n = 0 for 2 cycles, release, keep in_valid = 0.
   - Response: in_ready = 1, out_valid = 0, out_sel = 00, data_out = 00, words_sent = 0.
2. Both slots, no backpressure:
   - Stimulus: accept mask 11, data 0xA5/0x3C, out_ready = 1.
   - Response: next cycle data_out 0xA5 / sel 01, then 0x3C / sel 10, then IDLE; words_sent = 2.
3. Single-slot masks:
   - Stimulus: mask 10 with data_in_2 = 0x7E.
   - Response: one word 0x7E / sel 10.
   - Stimulus: mask 00.
   - Response: accepted, no out_valid, words_sent unchanged.
4. Backpressure:
   - Stimulus: mask 11 (0x11/0x22), out_ready low for 3 cycles during SEND1.
   - Response: 0x11 / sel 01 stays stable and in_ready = 0 throughout; 0x22 follows after release.
5. Back-to-back:
   - Stimulus: pairs (0x01, 0x02, mask 11) then (0x03, 0x04, mask 01), in_valid continuous, out_ready = 1.
   - Response: output 0x01, 0x02, 0x03 on consecutive cycles, with no bubble.
6. Reset mid-transfer and counter wrap:
   - Reset asserted in SEND1: next cycle IDLE, out_valid = 0.
   - Counter wrap: with CNT_WIDTH = 2, 5 transfers → words_sent = 1.
